// File: rtl/mannix_mem_pkg.sv
// Shared constants and types for the SRAM client arbiter.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
//
// Client numbering: 0-5 are read clients, 6-8 are write clients. The arbiter
// derives its write-enable from the owner index, so the write clients must
// stay at the top of the numbering.
package mannix_mem_pkg;

    localparam int N_CLIENTS = 9;
    localparam int ADDR_W    = 19;
    localparam int LEN_W     = 8;

    // Width of a client index as seen on arb_client.
    localparam int IDX_W     = 4;

    localparam int CL_FCC_PIC  = 0;
    localparam int CL_FCC_WGT  = 1;
    localparam int CL_FCC_BIAS = 2;
    localparam int CL_CNN_PIC  = 3;
    localparam int CL_CNN_WGT  = 4;
    localparam int CL_POOL_R   = 5;
    localparam int CL_FCC_W    = 6;
    localparam int CL_CNN_W    = 7;
    localparam int CL_POOL_W   = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mem_rr_pick.sv
// Round-robin search: first set request at or after ptr, wrapping past N-1 to 0.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is consumed.
//
// Ports: req   - request vector
//        ptr   - search start index (must be below N)
//        found - at least one request is set
//        idx   - index of the selected request (0 when nothing is found)
module mem_rr_pick #(
    parameter int N     = 9,
    parameter int IDX_W = 4
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

    always_comb begin
        logic [IDX_W:0] c;
        found = 1'b0;
        idx   = '0;
        c     = '0;
        // Walk the offsets from ptr upward; the first hit wins.
        for (int i = 0; i < N; i++) begin
            c = {1'b0, ptr} + (IDX_W+1)'(i);
            if (c >= (IDX_W+1)'(N)) begin
                c = c - (IDX_W+1)'(N);
            end
            if (!found && req[c[SEL_W-1:0]]) begin
                found = 1'b1;
                idx   = c[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mem_client_arb.sv
// SRAM burst arbiter: picks one client (absolute priority, else round robin),
// then streams its burst of line addresses to the memory controller.
// Latency: request seen in cycle N -> gnt and first beat in cycle N+1; done is
// pulsed the cycle after the last beat is accepted.
// Backpressure: arb_ready=0 freezes the current beat; new requests wait for IDLE.
//
// Ports: req/req_addr/req_len  - per-client request, start line, length (0 = 2^LEN_W)
//        client_priority       - absolute-priority client (>= N_CLIENTS disables)
//        gnt/done              - one-hot single-cycle pulses per client
//        arb_valid/arb_ready   - beat handshake toward the memory controller
//        arb_client/arb_we/arb_addr/arb_last - current beat attributes
//        busy                  - a burst is in progress
module mem_client_arb #(
    parameter int N_CLIENTS = mannix_mem_pkg::N_CLIENTS,
    parameter int ADDR_W    = mannix_mem_pkg::ADDR_W,
    parameter int LEN_W     = mannix_mem_pkg::LEN_W
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [N_CLIENTS-1:0]            req,
    input  logic [N_CLIENTS-1:0][ADDR_W-1:0] req_addr,
    input  logic [N_CLIENTS-1:0][LEN_W-1:0] req_len,
    input  logic [4:0]                      client_priority,
    output logic [N_CLIENTS-1:0]            gnt,
    output logic [N_CLIENTS-1:0]            done,
    output logic                            arb_valid,
    input  logic                            arb_ready,
    output logic [3:0]                      arb_client,
    output logic                            arb_we,
    output logic [ADDR_W-1:0]               arb_addr,
    output logic                            arb_last,
    output logic                            busy
);

    import mannix_mem_pkg::*;

    localparam int SEL_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

    arb_state_e       state;
    arb_state_e       state_nxt;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic             prio_hit;
    logic             grant;
    logic             beat_acc;
    logic             last_acc;
    // One extra bit so a zero length can hold the full 2^LEN_W beat count.
    logic [LEN_W:0]   rem;
    logic [LEN_W:0]   len_beats;

    mem_rr_pick #(
        .N     (N_CLIENTS),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Priority client only counts when it is a real client and is requesting.
    always_comb begin
        prio_hit = 1'b0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (client_priority == 5'(i) && req[i]) begin
                prio_hit = 1'b1;
            end
        end
    end

    assign winner    = prio_hit ? client_priority[IDX_W-1:0] : pick_idx;
    assign grant     = (state == ST_IDLE) && pick_found;
    assign beat_acc  = (state == ST_BURST) && arb_ready;
    assign last_acc  = beat_acc && (rem == (LEN_W+1)'(1));
    assign len_beats = (req_len[winner[SEL_W-1:0]] == '0)
                     ? {1'b1, {LEN_W{1'b0}}}
                     : {1'b0, req_len[winner[SEL_W-1:0]]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (grant)    state_nxt = ST_BURST;
            ST_BURST: if (last_acc) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            owner    <= '0;
            arb_addr <= '0;
            rem      <= '0;
            gnt      <= '0;
            done     <= '0;
        end else begin
            gnt  <= '0;
            done <= '0;
            if (grant) begin
                owner    <= winner;
                arb_addr <= req_addr[winner[SEL_W-1:0]];
                rem      <= len_beats;
                gnt      <= N_CLIENTS'(1) << winner;
                // Priority grants advance the pointer too, so the priority
                // client cannot leave the round robin stuck behind it.
                rr_ptr   <= (winner == IDX_W'(N_CLIENTS - 1)) ? '0 : winner + 1'b1;
            end else if (beat_acc) begin
                arb_addr <= arb_addr + 1'b1;
                rem      <= rem - 1'b1;
                if (last_acc) begin
                    done <= N_CLIENTS'(1) << owner;
                end
            end
        end
    end

    assign arb_valid  = (state == ST_BURST);
    assign busy       = (state == ST_BURST);
    assign arb_last   = (state == ST_BURST) && (rem == (LEN_W+1)'(1));
    assign arb_client = owner;
    assign arb_we     = (owner >= IDX_W'(CL_FCC_W));

endmodule

// File: tb/tb_mem_client_arb.sv
module tb_mem_client_arb;

    localparam int N  = 9;
    localparam int AW = 19;
    localparam int LW = 8;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [N-1:0]          req;
    logic [N-1:0][AW-1:0]  req_addr;
    logic [N-1:0][LW-1:0]  req_len;
    logic [4:0]            client_priority;
    logic [N-1:0]          gnt;
    logic [N-1:0]          done;
    logic                  arb_valid;
    logic                  arb_ready;
    logic [3:0]            arb_client;
    logic                  arb_we;
    logic [AW-1:0]         arb_addr;
    logic                  arb_last;
    logic                  busy;

    int n_checks = 0;
    int n_fail   = 0;
    int rr_model = 0;

    logic [AW-1:0] t_addr [N];
    logic [LW-1:0] t_len  [N];

    always #5 clk = ~clk;

    mem_client_arb #(.N_CLIENTS(N), .ADDR_W(AW), .LEN_W(LW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req             (req),
        .req_addr        (req_addr),
        .req_len         (req_len),
        .client_priority (client_priority),
        .gnt             (gnt),
        .done            (done),
        .arb_valid       (arb_valid),
        .arb_ready       (arb_ready),
        .arb_client      (arb_client),
        .arb_we          (arb_we),
        .arb_addr        (arb_addr),
        .arb_last        (arb_last),
        .busy            (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Arbitration rule: valid priority client first, else first requester
    // scanning upward from the round-robin pointer with wrap.
    function automatic int model_pick(input logic [N-1:0] mask, input logic [4:0] prio);
        if (int'(prio) < N && mask[prio]) return int'(prio);
        for (int i = 0; i < N; i++) begin
            if (mask[(rr_model + i) % N]) return (rr_model + i) % N;
        end
        return -1;
    endfunction

    task automatic drive_table();
        for (int i = 0; i < N; i++) begin
            req_addr[i] = t_addr[i];
            req_len[i]  = t_len[i];
        end
    endtask

    task automatic scramble_inputs();
        for (int i = 0; i < N; i++) begin
            req_addr[i] = AW'($urandom);
            req_len[i]  = LW'($urandom);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge where
    // done is visible (DUT idle again).
    // rdy_mode: 0 random, 1 always ready, 2 pattern from rdy_pat (then ready).
    task automatic run_burst(input logic [N-1:0] mask, input logic [4:0] prio,
                             input bit hold_req, input int rdy_mode,
                             input logic [15:0] rdy_pat);
        int            w;
        int            rem;
        int            k;
        logic          rdy;
        logic [AW-1:0] ea;
        drive_table();
        req             = mask;
        client_priority = prio;
        w = model_pick(mask, prio);
        if (w < 0) begin
            check_eq("no_winner", 32'(w), 32'(0));
            return;
        end
        rem      = (t_len[w] == '0) ? (1 << LW) : int'(t_len[w]);
        ea       = t_addr[w];
        rr_model = (w + 1) % N;
        @(posedge clk);
        @(negedge clk);
        check_eq("gnt", 32'(gnt), 32'(1) << w);
        check_eq("done_at_gnt", 32'(done), 32'(0));
        if (!hold_req) req = '0;
        scramble_inputs();
        client_priority = 5'($urandom);
        k = 0;
        while (rem > 0 && k < 4000) begin
            if (k > 0) begin
                check_eq("gnt_pulse", 32'(gnt), 32'(0));
                check_eq("done_early", 32'(done), 32'(0));
            end
            check_eq("valid",  32'(arb_valid),  32'(1));
            check_eq("busy",   32'(busy),       32'(1));
            check_eq("addr",   32'(arb_addr),   32'(ea));
            check_eq("last",   32'(arb_last),   32'(rem == 1));
            check_eq("client", 32'(arb_client), 32'(w));
            check_eq("we",     32'(arb_we),     32'(w >= 6));
            if (rdy_mode == 1)      rdy = 1'b1;
            else if (rdy_mode == 2) rdy = (k < 16) ? rdy_pat[k] : 1'b1;
            else                    rdy = ($urandom_range(0, 3) != 0);
            arb_ready = rdy;
            @(posedge clk);
            @(negedge clk);
            if (rdy) begin
                rem--;
                ea = ea + 1'b1;
            end
            k++;
        end
        if (rem > 0) check_eq("beat_budget", 32'(rem), 32'(0));
        check_eq("done",      32'(done),      32'(1) << w);
        check_eq("valid_end", 32'(arb_valid), 32'(0));
        check_eq("busy_end",  32'(busy),      32'(0));
        check_eq("gnt_end",   32'(gnt),       32'(0));
        arb_ready = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_gnt"},    32'(gnt),        32'(0));
        check_eq({tag, "_done"},   32'(done),       32'(0));
        check_eq({tag, "_valid"},  32'(arb_valid),  32'(0));
        check_eq({tag, "_last"},   32'(arb_last),   32'(0));
        check_eq({tag, "_we"},     32'(arb_we),     32'(0));
        check_eq({tag, "_busy"},   32'(busy),       32'(0));
        check_eq({tag, "_client"}, 32'(arb_client), 32'(0));
        check_eq({tag, "_addr"},   32'(arb_addr),   32'(0));
    endtask

    task automatic randomize_table(input int max_len);
        for (int i = 0; i < N; i++) begin
            t_addr[i] = AW'($urandom);
            t_len[i]  = LW'($urandom_range(1, max_len));
        end
    endtask

    initial begin
        logic [N-1:0] m;
        logic [4:0]   p;
        rst_n           = 1'b0;
        req             = '0;
        arb_ready       = 1'b0;
        client_priority = 5'd31;
        for (int i = 0; i < N; i++) begin
            t_addr[i] = '0;
            t_len[i]  = '0;
        end
        drive_table();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Held full request, no priority: grant order 0..8 then 0 again.
        randomize_table(3);
        for (int i = 0; i < 10; i++) run_burst(9'h1FF, 5'd31, 1'b1, 0, 16'h0);

        // Single client 2, three beats from 0x100.
        randomize_table(4);
        t_addr[2] = 19'h00100;
        t_len[2]  = 8'd3;
        run_burst(9'h004, 5'd31, 1'b0, 1, 16'h0);

        // Priority client 5 wins every round, then priority 9 means none.
        for (int i = 0; i < 4; i++) run_burst(9'h1FF, 5'd5, 1'b1, 0, 16'h0);
        for (int i = 0; i < 9; i++) run_burst(9'h1FF, 5'd9, 1'b1, 0, 16'h0);

        // Write client 7 wrapping the address space under backpressure.
        t_addr[7] = 19'h7FFFF;
        t_len[7]  = 8'd2;
        run_burst(9'h080, 5'd31, 1'b0, 2, 16'hFFF9);

        // Zero length means a full 256-beat burst.
        t_addr[3] = 19'h12345;
        t_len[3]  = 8'd0;
        run_burst(9'h008, 5'd31, 1'b0, 0, 16'h0);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            randomize_table(8);
            m = N'($urandom_range(1, (1 << N) - 1));
            case ($urandom_range(0, 3))
                0:       p = 5'd31;
                1:       p = 5'd9;
                2:       p = 5'($urandom_range(0, N - 1));
                default: p = 5'($urandom);
            endcase
            run_burst(m, p, bit'($urandom_range(0, 1)), 0, 16'h0);
        end

        // Reset during beat 2 of a 4-beat burst.
        t_addr[4] = 19'h01234;
        t_len[4]  = 8'd4;
        drive_table();
        req             = 9'h010;
        client_priority = 5'd31;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_gnt", 32'(gnt), 32'h010);
        req       = '0;
        arb_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_beat2_addr", 32'(arb_addr), 32'h01235);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_async");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("rst_hold_done", 32'(done), 32'(0));
        end
        arb_ready = 1'b0;
        rst_n     = 1'b1;
        rr_model  = 0;
        @(negedge clk);
        check_all_zero("post_rst");
        // With the pointer back at 0, client 4 must win over 5..8.
        randomize_table(3);
        run_burst(9'h1F0, 5'd31, 1'b0, 1, 16'h0);
        run_burst(9'h1FF, 5'd31, 1'b0, 0, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_client_arb.md
MEM_CLIENT_ARB -- requirements
Module: mem_client_arb

Interface
REQ-001 Parameter N_CLIENTS, default 9, number of requesters; index 0-5 are read clients fcc_pic, fcc_wgt, fcc_bias, cnn_pic, cnn_wgt, pool; index 6-8 are write clients fcc, cnn, pool.
REQ-002 Parameter ADDR_W, default 19, SRAM line-address width.
REQ-003 Parameter LEN_W, default 8, burst-length width in lines.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req  input  N_CLIENTS  per-client request level.
REQ-007 req_addr  input  N_CLIENTS x ADDR_W  per-client start line address.
REQ-008 req_len  input  N_CLIENTS x LEN_W  per-client burst length; value 0 means 2^LEN_W lines.
REQ-009 client_priority  input  5  index of the absolute-priority client; a value >= N_CLIENTS means pure round robin.
REQ-010 gnt  output  N_CLIENTS  one-hot, one-cycle pulse when a client's request is accepted.
REQ-011 done  output  N_CLIENTS  one-hot, one-cycle pulse when the granted client's last line is accepted downstream.
REQ-012 arb_valid  output  1  beat valid toward the memory controller.
REQ-013 arb_ready  input  1  memory controller accepts the beat.
REQ-014 arb_client  output  4  index of the owning client.
REQ-015 arb_we  output  1  1 when the owner index is 6 or higher.
REQ-016 arb_addr  output  ADDR_W  current line address.
REQ-017 arb_last  output  1  the current beat is the final beat of the burst.
REQ-018 busy  output  1  the FSM is in the BURST state.

Function
REQ-019 The FSM shall have two states: IDLE and BURST.
REQ-020 In IDLE, if any req bit is set at cycle N, the block shall select a winner and, in cycle N+1, enter BURST, assert gnt[winner] for one cycle, and drive arb_valid=1 with arb_addr=req_addr[winner].
REQ-021 Winner selection: client_priority wins if it is below N_CLIENTS and its req bit is set; otherwise the first set req at or after rr_ptr, searching upward with wrap from N_CLIENTS-1 to 0.
REQ-022 On every grant, rr_ptr shall become (winner+1) mod N_CLIENTS, including grants won through priority.
REQ-023 At grant, the block shall latch addr, len, and owner; the requester may change req, addr, and len from the cycle after gnt onward.
REQ-024 In BURST, each cycle with arb_valid&&arb_ready shall increment arb_addr by 1 modulo 2^ADDR_W and decrement the remaining-beat counter.
REQ-025 While arb_ready=0, arb_addr, arb_last, arb_client, and arb_we shall be held stable.
REQ-026 arb_last shall equal 1 exactly when the remaining count is 1; for len=0, the burst shall be 256 beats when LEN_W=8.
REQ-027 When the last beat is accepted, the block shall pulse done[owner], drop arb_valid in the next cycle, and return to IDLE; the minimum gap between bursts is one idle cycle.
REQ-028 Requests arriving during BURST shall be ignored until IDLE; req deassert during BURST shall not affect the burst.
REQ-029 A change of client_priority during BURST shall take effect at the next arbitration only.
REQ-030 gnt and done for the same client shall never be asserted in the same cycle; a 1-beat burst yields gnt at cycle N+1 and done no earlier than N+1 plus the ready delay.

Reset
REQ-031 While rst_n=0, the block shall force state=IDLE, rr_ptr=0, and gnt, done, arb_valid, arb_last, arb_we, busy to 0, and arb_client, arb_addr to 0.
REQ-032 Reset asserted mid-burst shall abort the burst with no done pulse; the first edge after release shall behave as IDLE.

Structure
REQ-033 Package mannix_mem_pkg shall hold the client index constants (CL_FCC_PIC=0 .. CL_POOL_W=8), N_CLIENTS, ADDR_W, LEN_W, and the state enum.
REQ-034 Masked round-robin search shall be a combinational sub-module named mem_rr_pick (inputs req, ptr; outputs found, idx).

Verification
REQ-035 Test 1: req=0x004, addr=0x100, len=3, priority=31, ready=1 -> gnt[2] at N+1; addresses 0x100, 0x101, 0x102; arb_last on 0x102; done[2]; then IDLE.
REQ-036 Test 2: req=0x1FF held, priority=31 -> grant order 0,1,...,8,0, with rr_ptr wrapping.
REQ-037 Test 3: req=0x1FF, priority=5 -> client 5 wins every arbitration while requesting; with priority=9 -> pure round robin.
REQ-038 Test 4: client 7, addr=0x7FFFF, len=2, ready toggling 1,0,0,1 -> addresses 0x7FFFF then 0x00000; arb_we=1; outputs stable during ready=0.
REQ-039 Test 5: len=0 -> exactly 256 accepted beats, arb_last only on the 256th beat.
REQ-040 Test 6: rst_n low on beat 2 of a 4-beat burst -> all outputs 0 asynchronously, no done pulse; next request is granted from rr_ptr=0.
